// File: rtl/switch_out_arbiter.sv
// -----------------------------------------------------------------------------
// switch_out_arbiter
//
// Round-robin arbiter and registered output stage for one egress port of
// switch_4port. Each ingress port presents the head of its queue, already
// filtered for this egress. A winner stays locked until the beat flagged
// last has been loaded, so multi-beat packets leave the port contiguously.
//
// Ports:
//   clk         single clock
//   rst_n       synchronous active-low reset
//   req_valid   [NUM_PORTS]         requester i has a beat for this egress
//   req_source  [NUM_PORTS*ID_W]    source id, slice i = [i*ID_W +: ID_W]
//   req_data    [NUM_PORTS*DATA_W]  data beat, slice i = [i*DATA_W +: DATA_W]
//   req_last    [NUM_PORTS]         beat closes its packet
//   req_ready   [NUM_PORTS]         one-hot combinational pop to requester i
//   out_valid   registered beat valid
//   out_source  registered source id
//   out_target  PORT_ID while out_valid, 0 otherwise
//   out_data    registered data beat
//   out_last    registered last flag
//   out_ready   downstream accepts when out_valid && out_ready
//   out_grant   [NUM_PORTS] one-hot owner of the packet in the register
// -----------------------------------------------------------------------------
module switch_out_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 8,
    parameter int ID_W      = 2,
    parameter int PORT_ID   = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_PORTS-1:0]          req_valid,
    input  logic [NUM_PORTS*ID_W-1:0]     req_source,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_data,
    input  logic [NUM_PORTS-1:0]          req_last,
    output logic [NUM_PORTS-1:0]          req_ready,
    output logic                          out_valid,
    output logic [ID_W-1:0]               out_source,
    output logic [ID_W-1:0]               out_target,
    output logic [DATA_W-1:0]             out_data,
    output logic                          out_last,
    input  logic                          out_ready,
    output logic [NUM_PORTS-1:0]          out_grant
);

    localparam int PTR_W = $clog2(NUM_PORTS);

    localparam logic [0:0] ST_ARB  = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    logic [0:0]           state;
    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     lock_idx;

    logic                 out_free;
    logic [NUM_PORTS-1:0] req_rot;
    logic [PTR_W:0]       cand_sum;
    logic                 arb_any;
    logic [PTR_W-1:0]     arb_idx;
    logic [PTR_W-1:0]     rr_next;
    logic                 lock_valid;
    logic [PTR_W-1:0]     sel_idx;
    logic [NUM_PORTS-1:0] sel_onehot;
    logic [DATA_W-1:0]    sel_data;
    logic [ID_W-1:0]      sel_source;
    logic                 sel_last;
    logic                 load;

    // The register can take a new beat when it is empty or being drained
    // this same cycle; this is what gives pass-through without a bubble.
    assign out_free = !out_valid || out_ready;

    // Round-robin search: rotate the request vector so rr_ptr sits at bit 0,
    // take the lowest set bit, then rotate the index back.
    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        req_rot  = NUM_PORTS'({req_valid, req_valid} >> rr_ptr);
        arb_any  = 1'b0;
        arb_idx  = '0;
        cand_sum = '0;
        // Descending loop: the lowest rotated offset is assigned last and wins.
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                arb_any  = 1'b1;
                cand_sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
                if (cand_sum >= (PTR_W+1)'(NUM_PORTS)) begin
                    cand_sum = cand_sum - (PTR_W+1)'(NUM_PORTS);
                end
                arb_idx = cand_sum[PTR_W-1:0];
            end
        end
    end

    assign rr_next    = (arb_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : arb_idx + PTR_W'(1);
    assign lock_valid = req_valid[lock_idx];
    assign sel_idx    = (state == ST_ARB) ? arb_idx : lock_idx;
    assign sel_onehot = {{(NUM_PORTS-1){1'b0}}, 1'b1} << sel_idx;

    // rst_n gates the load so nothing is popped while reset is held.
    assign load = rst_n && out_free && ((state == ST_ARB) ? arb_any : lock_valid);

    assign req_ready = load ? sel_onehot : '0;

    // Beat mux for the selected requester.
    always_comb begin
        sel_data   = '0;
        sel_source = '0;
        sel_last   = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (sel_idx == PTR_W'(i)) begin
                sel_data   = req_data[i*DATA_W +: DATA_W];
                sel_source = req_source[i*ID_W +: ID_W];
                sel_last   = req_last[i];
            end
        end
    end

    // Output register and arbitration state.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
            out_source <= '0;
            out_target <= '0;
            out_grant  <= '0;
            state      <= ST_ARB;
            rr_ptr     <= '0;
            lock_idx   <= '0;
        end else begin
            if (load) begin
                out_valid  <= 1'b1;
                out_data   <= sel_data;
                out_source <= sel_source;
                out_last   <= sel_last;
                out_target <= ID_W'(PORT_ID);
                out_grant  <= sel_onehot;
            end else if (out_ready) begin
                out_valid  <= 1'b0;
                out_target <= '0;
                // Inside a packet the owner survives a gap; only an idle
                // arbiter forgets it.
                if (state == ST_ARB) begin
                    out_grant <= '0;
                end
            end

            if (load) begin
                if (state == ST_ARB) begin
                    rr_ptr <= rr_next;
                    if (!sel_last) begin
                        state    <= ST_LOCK;
                        lock_idx <= arb_idx;
                    end
                end else if (sel_last) begin
                    state <= ST_ARB;
                end
            end
        end
    end

endmodule
